// File: rtl/scan_pkg.sv
// Shared definitions for the decoder scan sequencer.
//   ADDR_W_DEFAULT  : default decoder select width (2^ADDR_W outputs)
//   DWELL_W_DEFAULT : default dwell counter width
//   ST_IDLE/ST_SCAN : state encoding, wrapped in the state_e enum
package scan_pkg;

  localparam int ADDR_W_DEFAULT  = 4;
  localparam int DWELL_W_DEFAULT = 8;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SCAN = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    SCAN = ST_SCAN
  } state_e;

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for the scan sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear of the count (highest priority)
//   en_i       : count enable; the count returns to 0 after reaching limit_i
//   limit_i    : terminal value (dwell - 1 hold cycles)
//   tc_o       : terminal count, high while cnt == limit_i
module dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Compare happens before increment, so a limit of all-ones never overflows.
  assign tc_o = (cnt_q == limit_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Drives the enable/A pair of a 4-to-16 decoder, stepping A through
// [first_addr..last_addr] (modulo 2^ADDR_W) and holding each address for
// dwell+1 cycles. Single-pass or continuous scan with start/stop control.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start, stop                : level controls, sampled every cycle
//   continuous                 : 1 = wrap last->first forever
//   first_addr, last_addr      : scan range (captured at start)
//   dwell                      : hold time per address minus one (captured)
//   A, enable                  : registered decoder select and enable
//   busy                       : high while scanning (always equals enable)
//   done                       : 1-cycle pulse at the end of a single pass
//   wrap                       : 1-cycle pulse on each last->first return
module decoder_scan_sequencer
  import scan_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DWELL_W = DWELL_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [ADDR_W-1:0]  first_addr,
  input  logic [ADDR_W-1:0]  last_addr,
  input  logic [DWELL_W-1:0] dwell,
  output logic [ADDR_W-1:0]  A,
  output logic               enable,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  state_e              state_q;
  logic [ADDR_W-1:0]   a_q;
  logic                enable_q;
  logic                busy_q;
  logic                done_q;
  logic                wrap_q;

  // Shadow copies so input changes mid-scan are ignored.
  logic [ADDR_W-1:0]   first_q;
  logic [ADDR_W-1:0]   last_q;
  logic [DWELL_W-1:0]  dwell_q;
  logic                cont_q;

  logic [ADDR_W-1:0]   a_inc_d;
  logic                hold_end;
  logic                tmr_clr;
  logic                tmr_en;

  assign a_inc_d = a_q + 1'b1;  // natural modulo 2^ADDR_W wrap

  // Counter restarts from 0 whenever a scan is not running or is being
  // aborted, so each new scan starts with a full first window.
  assign tmr_clr = (state_q == IDLE) || stop;
  assign tmr_en  = (state_q == SCAN);

  dwell_timer #(.W(DWELL_W)) u_dwell_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (dwell_q),
    .tc_o    (hold_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      first_q  <= '0;
      last_q   <= '0;
      dwell_q  <= '0;
      cont_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            first_q  <= first_addr;
            last_q   <= last_addr;
            dwell_q  <= dwell;
            cont_q   <= continuous;
            a_q      <= first_addr;
            enable_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= SCAN;
          end
        end
        SCAN: begin
          // stop outranks any coincident hold-end, wrap or done.
          if (stop) begin
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else if (hold_end) begin
            if (a_q != last_q) begin
              a_q <= a_inc_d;
            end else if (cont_q) begin
              a_q    <= first_q;
              wrap_q <= 1'b1;
            end else begin
              enable_q <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign A      = a_q;
  assign enable = enable_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
module tb_decoder_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       continuous = 1'b0;
  logic [3:0] first_addr = '0;
  logic [3:0] last_addr = '0;
  logic [7:0] dwell = '0;
  logic [3:0] A;
  logic       enable;
  logic       busy;
  logic       done;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       en;
    logic [3:0] a;
    logic       dn;
    logic       wr;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  decoder_scan_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .dwell      (dwell),
    .A          (A),
    .enable     (enable),
    .busy       (busy),
    .done       (done),
    .wrap       (wrap)
  );

  // Monitor: every cycle the DUT presents an output (enable, done or wrap),
  // pop the next expected beat and compare.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (enable !== busy || (done && wrap)) begin
        errors++;
        $display("FAIL flags: enable=%b busy=%b done=%b wrap=%b (need enable==busy, not done&&wrap)",
                 enable, busy, done, wrap);
      end
      if (enable || done || wrap) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected: got en=%b A=%0d done=%b wrap=%b, none expected",
                   enable, A, done, wrap);
        end else begin
          exp_t e;
          exp_t got;
          e   = exp_q.pop_front();
          got = '{en: enable, a: A, dn: done, wr: wrap};
          if (got !== e) begin
            errors++;
            $display("FAIL beat: got en=%b A=%0d done=%b wrap=%b, need en=%b A=%0d done=%b wrap=%b",
                     got.en, got.a, got.dn, got.wr, e.en, e.a, e.dn, e.wr);
          end
        end
      end
    end
  end

  task automatic push_hold(input logic [3:0] a, input int n, input logic wr_first);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{en: 1'b1, a: a, dn: 1'b0, wr: (i == 0) ? wr_first : 1'b0});
    end
  endtask

  task automatic push_done(input logic [3:0] a);
    exp_q.push_back('{en: 1'b0, a: a, dn: 1'b1, wr: 1'b0});
  endtask

  // Drive one start request; returns #1 after the capturing edge.
  task automatic kick(input logic [3:0] f, input logic [3:0] l, input logic [7:0] d,
                      input logic c);
    first_addr = f;
    last_addr  = l;
    dwell      = d;
    continuous = c;
    start      = 1'b1;
    $display("scan first=%0d last=%0d dwell=%0d continuous=%b", f, l, d, c);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int bound);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < bound) begin
      @(posedge clk);
      i++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: %0d beats still pending, need 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name, input logic [3:0] a_exp);
    @(negedge clk);
    checks++;
    if (A !== a_exp || enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL %s: got A=%0d en=%b busy=%b done=%b wrap=%b, need A=%0d en=0 busy=0 done=0 wrap=0",
               name, A, enable, busy, done, wrap, a_exp);
    end
  endtask

  initial begin
    // 1: reset with random inputs
    for (int i = 0; i < 5; i++) begin
      start      = 1'($urandom);
      stop       = 1'($urandom);
      continuous = 1'($urandom);
      first_addr = 4'($urandom);
      last_addr  = 4'($urandom);
      dwell      = 8'($urandom);
      check_idle("reset", 4'd0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 2: single pass 2..5, dwell 1
    push_hold(4'd2, 2, 1'b0);
    push_hold(4'd3, 2, 1'b0);
    push_hold(4'd4, 2, 1'b0);
    push_hold(4'd5, 2, 1'b0);
    push_done(4'd5);
    kick(4'd2, 4'd5, 8'd1, 1'b0);
    wait_empty("pass_2_5", 40);
    check_idle("after_pass_2_5", 4'd5);

    // 3: range wraps through 15->0
    push_hold(4'd14, 1, 1'b0);
    push_hold(4'd15, 1, 1'b0);
    push_hold(4'd0, 1, 1'b0);
    push_hold(4'd1, 1, 1'b0);
    push_done(4'd1);
    kick(4'd14, 4'd1, 8'd0, 1'b0);
    wait_empty("wrap_range", 40);

    // 4: continuous 0..2, stop while A=1 on the third lap
    push_hold(4'd0, 1, 1'b0);
    push_hold(4'd1, 1, 1'b0);
    push_hold(4'd2, 1, 1'b0);
    push_hold(4'd0, 1, 1'b1);
    push_hold(4'd1, 1, 1'b0);
    push_hold(4'd2, 1, 1'b0);
    push_hold(4'd0, 1, 1'b1);
    push_hold(4'd1, 1, 1'b0);
    kick(4'd0, 4'd2, 8'd0, 1'b1);
    repeat (7) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    check_idle("after_stop", 4'd1);
    wait_empty("continuous", 10);

    // 5: start and input changes while busy are ignored
    push_hold(4'd3, 3, 1'b0);
    push_hold(4'd4, 3, 1'b0);
    push_done(4'd4);
    kick(4'd3, 4'd4, 8'd2, 1'b0);
    @(posedge clk);
    #1;
    start      = 1'b1;
    first_addr = 4'd9;
    last_addr  = 4'd12;
    dwell      = 8'd0;
    continuous = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    wait_empty("busy_ignore", 40);
    check_idle("after_busy_ignore", 4'd4);
    // start together with stop keeps the sequencer idle
    first_addr = 4'd0;
    last_addr  = 4'd0;
    start = 1'b1;
    stop  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    check_idle("start_stop_idle", 4'd4);

    // single address, maximum dwell: held 256 cycles then done
    push_hold(4'd10, 256, 1'b0);
    push_done(4'd10);
    kick(4'd10, 4'd10, 8'd255, 1'b0);
    wait_empty("dwell_max", 400);

    // 6: async reset mid-dwell at A=7
    push_hold(4'd6, 4, 1'b0);
    push_hold(4'd7, 2, 1'b0);
    kick(4'd6, 4'd9, 8'd3, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (A !== 4'd0 || enable !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got A=%0d en=%b busy=%b before clk, need A=0 en=0 busy=0",
               A, enable, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pre_reset_beats: %0d pending, need 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_hold(4'd7, 2, 1'b0);
    push_hold(4'd8, 2, 1'b0);
    push_done(4'd8);
    kick(4'd7, 4'd8, 8'd1, 1'b0);
    wait_empty("after_reset_scan", 40);
    check_idle("final_idle", 4'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
